// File: rtl/act_pkg.sv
// rtl/act_pkg.sv - activation mode encodings shared by act_pipe and the layer controller
// Ports: none (package)
package act_pkg;

  // cfg_mode encodings
  localparam logic [1:0] ACT_BYPASS = 2'd0;
  localparam logic [1:0] ACT_RELU   = 2'd1;
  localparam logic [1:0] ACT_CLIP   = 2'd2;
  localparam logic [1:0] ACT_LEAKY  = 2'd3;

endpackage

// File: rtl/act_lane.sv
// rtl/act_lane.sv - combinational single-lane activation function
// Ports:
//   x    in  DATA_WIDTH    signed lane value
//   mode in  2             activation mode (act_pkg encodings)
//   clip in  DATA_WIDTH-1  unsigned ceiling for clipped ReLU
//   y    out DATA_WIDTH    signed activated value
module act_lane #(
  parameter int DATA_WIDTH  = 8,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-2:0] clip,
  output logic [DATA_WIDTH-1:0] y
);
  import act_pkg::*;

  logic x_neg;
  logic x_zero;

  assign x_neg  = x[DATA_WIDTH-1];
  assign x_zero = (x == '0);

  always_comb begin
    y = x;
    case (mode)
      ACT_BYPASS: y = x;
      ACT_RELU: begin
        if (x_neg || x_zero) y = '0;
      end
      ACT_CLIP: begin
        // x is known positive here, so its low bits are its magnitude
        if (x_neg || x_zero) y = '0;
        else if (x[DATA_WIDTH-2:0] > clip) y = {1'b0, clip};
      end
      ACT_LEAKY: begin
        // arithmetic shift floors, so small negatives settle at -1 rather than 0
        if (x_neg) y = $signed(x) >>> LEAKY_SHIFT;
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/act_pipe.sv
// rtl/act_pipe.sv - multi-lane two-stage activation pipeline with zero-lane counter
// Ports:
//   clk       in  1                 clock, rising edge
//   rst_n     in  1                 asynchronous active-low reset
//   in_valid  in  1                 input beat valid
//   in_ready  out 1                 input beat accepted on in_valid & in_ready
//   in_data   in  LANES*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   cfg_mode  in  2                 activation mode, captured with the beat
//   cfg_clip  in  DATA_WIDTH-1      clip ceiling, captured with the beat
//   out_valid out 1                 output beat valid
//   out_ready in  1                 downstream accept
//   out_data  out LANES*DATA_WIDTH  activated lanes, same packing as in_data
//   stat_clr  in  1                 synchronous clear of zero_cnt
//   zero_cnt  out CNT_WIDTH         saturating count of delivered zero lanes
module act_pipe #(
  parameter int DATA_WIDTH  = 8,
  parameter int LANES       = 4,
  parameter int LEAKY_SHIFT = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic [1:0]                  cfg_mode,
  input  logic [DATA_WIDTH-2:0]       cfg_clip,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  input  logic                        stat_clr,
  output logic [CNT_WIDTH-1:0]        zero_cnt
);
  import act_pkg::*;

  localparam int W = LANES * DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] ONE_CNT = CNT_WIDTH'(1);

  logic                  s1_valid_q, s1_valid_d;
  logic [W-1:0]          s1_data_q,  s1_data_d;
  logic [1:0]            s1_mode_q,  s1_mode_d;
  logic [DATA_WIDTH-2:0] s1_clip_q,  s1_clip_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [W-1:0]          s2_data_q,  s2_data_d;
  logic [CNT_WIDTH-1:0]  zero_cnt_q, zero_cnt_d;

  logic                  s1_adv;
  logic                  s2_adv;
  logic                  out_hs;
  logic [W-1:0]          lane_res;
  logic [CNT_WIDTH-1:0]  zero_lanes;
  logic [CNT_WIDTH:0]    cnt_sum;

  // A stage may load when it is empty or its content leaves this cycle;
  // chaining through out_ready keeps full throughput without a bubble.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign out_hs   = s2_valid_q && out_ready;

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign zero_cnt  = zero_cnt_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .LEAKY_SHIFT(LEAKY_SHIFT)
    ) u_lane (
      .x   (s1_data_q[i*DATA_WIDTH +: DATA_WIDTH]),
      .mode(s1_mode_q),
      .clip(s1_clip_q),
      .y   (lane_res[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s1_clip_d  = s1_clip_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_mode_d = cfg_mode;
        s1_clip_d = cfg_clip;
      end
    end

    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_data_d = lane_res;
    end
  end

  always_comb begin
    zero_lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s2_data_q[i*DATA_WIDTH +: DATA_WIDTH] == '0) zero_lanes = zero_lanes + ONE_CNT;
    end
    cnt_sum    = {1'b0, zero_cnt_q} + {1'b0, zero_lanes};
    zero_cnt_d = zero_cnt_q;
    // clear beats a simultaneous handshake: that beat is not counted
    if (stat_clr) zero_cnt_d = '0;
    else if (out_hs) zero_cnt_d = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= ACT_BYPASS;
      s1_clip_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      zero_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s1_clip_q  <= s1_clip_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end

endmodule

// File: tb/tb_act_pipe.sv
// tb/tb_act_pipe.sv - scoreboard testbench for act_pipe
module tb_act_pipe;
  localparam int DW = 8;
  localparam int LANES = 4;
  localparam int SH = 3;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic [1:0]    cfg_mode;
  logic [DW-2:0] cfg_clip;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          stat_clr;
  logic [CW-1:0] zero_cnt;

  act_pipe #(
    .DATA_WIDTH (DW),
    .LANES      (LANES),
    .LEAKY_SHIFT(SH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .cfg_mode (cfg_mode),
    .cfg_clip (cfg_clip),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .stat_clr (stat_clr),
    .zero_cnt (zero_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] sb[$];
  logic [31:0] exp_beat;
  logic [31:0] held;
  int          exp_cnt;
  int          rdy_mode;
  int          n_pass;
  int          n_total;
  bit          stall_prev;

  function automatic int lane_model(int x, int mode, int clip);
    case (mode)
      0: return x;
      1: return (x > 0) ? x : 0;
      2: begin
        if (x <= 0) return 0;
        return (x < clip) ? x : clip;
      end
      default: begin
        if (x >= 0) return x;
        return -((-x + (2 ** SH) - 1) / (2 ** SH));
      end
    endcase
  endfunction

  function automatic logic [31:0] beat_model(logic [31:0] d, int mode, int clip);
    logic [31:0] r;
    logic [7:0]  b;
    int          v;
    for (int i = 0; i < LANES; i++) begin
      b = d[i*DW +: DW];
      v = lane_model(int'($signed(b)), mode, clip);
      r[i*DW +: DW] = 8'(v);
    end
    return r;
  endfunction

  function automatic logic [31:0] pk(int l0, int l1, int l2, int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  function automatic int nzero(logic [31:0] d);
    int n = 0;
    for (int i = 0; i < LANES; i++) if (d[i*DW +: DW] == 8'd0) n++;
    return n;
  endfunction

  task automatic chk(bit ok, string name, logic [31:0] act, logic [31:0] expv);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
  endtask

  // Presents one beat from posedge+1 and returns at posedge+1 after it is taken.
  task automatic send(logic [31:0] d, int mode, int clip, logic [31:0] expv);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    cfg_mode = 2'(mode);
    cfg_clip = 7'(clip);
    exp_beat = expv;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) chk(1'b0, "in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    cfg_mode = 2'($urandom);
    cfg_clip = 7'($urandom);
  endtask

  task automatic send_m(logic [31:0] d, int mode, int clip);
    send(d, mode, clip, beat_model(d, mode, clip));
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(sb.size() == 0, "drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] e;
    int          hz;
    bit          hs;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; cfg_mode = '0; cfg_clip = '0;
    out_ready = 1'b1; stat_clr = 1'b0; exp_beat = '0; held = '0;
    exp_cnt = 0; rdy_mode = 0; n_pass = 0; n_total = 0; stall_prev = 1'b0;

    fork
      forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
      end
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          sb.delete();
          exp_cnt = 0;
          stall_prev = 1'b0;
        end else begin
          chk(zero_cnt == CW'(exp_cnt), "zero_cnt", 32'(zero_cnt), 32'(exp_cnt));
          if (stall_prev) begin
            chk(out_valid, "stall_valid", 32'(out_valid), 32'd1);
            chk(out_data === held, "stall_data", out_data, held);
          end
          hs = out_valid && out_ready;
          hz = 0;
          if (hs) begin
            if (sb.size() == 0) chk(1'b0, "unexpected_beat", out_data, 32'd0);
            else begin
              e = sb.pop_front();
              chk(out_data === e, "out_data", out_data, e);
              hz = nzero(e);
            end
          end
          if (stat_clr) exp_cnt = 0;
          else if (hs) exp_cnt = (exp_cnt + hz > CNT_MAX) ? CNT_MAX : exp_cnt + hz;
          if (in_valid && in_ready) sb.push_back(exp_beat);
          stall_prev = out_valid && !out_ready;
          held = out_data;
        end
      end
    join_none

    #2;
    chk(out_valid == 1'b0, "reset_out_valid", 32'(out_valid), 32'd0);
    chk(out_data == 32'd0, "reset_out_data", out_data, 32'd0);
    chk(zero_cnt == '0, "reset_zero_cnt", 32'(zero_cnt), 32'd0);
    chk(in_ready == 1'b1, "reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ReLU beat with latency check: accepted at edge k, visible after k+1
    send(pk(-128, -1, 0, 127), 1, 0, pk(0, 0, 0, 127));
    chk(out_valid == 1'b0, "latency_s1_only", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk(out_valid == 1'b1, "latency_valid", 32'(out_valid), 32'd1);
    chk(out_data == pk(0, 0, 0, 127), "latency_data", out_data, pk(0, 0, 0, 127));
    drain();
    chk(zero_cnt == 16'd3, "relu_zero_cnt", 32'(zero_cnt), 32'd3);

    send(pk(5, 6, 7, -3), 2, 6, pk(5, 6, 6, 0));
    send(pk(1, 2, 3, 4), 2, 0, pk(0, 0, 0, 0));
    send(pk(-128, -1, -9, 40), 3, 0, pk(-16, -1, -2, 40));
    send(pk(-5, 3, 0, -128), 0, 0, pk(-5, 3, 0, -128));
    send(pk(127, -128, 1, -2), 2, 127, pk(127, 0, 1, 0));
    drain();

    // random beats, config change every beat, random backpressure and gaps
    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      send_m($urandom, int'($urandom_range(0, 3)),
             ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 127)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    drain();
    rdy_mode = 0;
    out_ready = 1'b1;

    // counter saturation
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    chk(zero_cnt == '0, "clr_idle", 32'(zero_cnt), 32'd0);
    for (int i = 0; i < 16383; i++) send(32'd0, 0, 0, 32'd0);
    drain();
    chk(zero_cnt == 16'd65532, "cnt_65532", 32'(zero_cnt), 32'd65532);
    send(pk(0, 0, 1, 1), 0, 0, pk(0, 0, 1, 1));
    drain();
    chk(zero_cnt == 16'd65534, "cnt_65534", 32'(zero_cnt), 32'd65534);
    send(32'd0, 0, 0, 32'd0);
    drain();
    chk(zero_cnt == 16'hFFFF, "cnt_saturate", 32'(zero_cnt), 32'd65535);
    send(32'd0, 1, 0, 32'd0);
    drain();
    chk(zero_cnt == 16'hFFFF, "cnt_stay_sat", 32'(zero_cnt), 32'd65535);
    stat_clr = 1'b1;
    send(32'd0, 0, 0, 32'd0);
    drain();
    stat_clr = 1'b0;
    chk(zero_cnt == '0, "clr_with_hs", 32'(zero_cnt), 32'd0);
    send(pk(-1, -2, 0, 0), 1, 0, pk(0, 0, 0, 0));
    drain();
    chk(zero_cnt == 16'd4, "cnt_after_clr", 32'(zero_cnt), 32'd4);

    // reset with both stages full
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    send(pk(10, 20, 30, 40), 0, 0, pk(10, 20, 30, 40));
    send(pk(-10, 20, -30, 40), 1, 0, pk(0, 20, 0, 40));
    chk(in_ready == 1'b0, "full_in_ready", 32'(in_ready), 32'd0);
    chk(out_valid == 1'b1, "full_out_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk(out_valid == 1'b0, "rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk(zero_cnt == '0, "rst_mid_zero_cnt", 32'(zero_cnt), 32'd0);
    chk(in_ready == 1'b1, "rst_mid_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(pk(-128, -1, -9, 40), 3, 0, pk(-16, -1, -2, 40));
    drain();
    chk(zero_cnt == '0, "post_rst_cnt", 32'(zero_cnt), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
